// File: rtl/load_store_unit.sv
// Memory-access stage for the rv32i data path: runs one byte/half/word load or store
// on a word-wide req/ack memory port, with alignment, funct3 and timeout checking.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic        load,
  input  logic        store,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   lane_wdata = {4{d[7:0]}};
      2'b01:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_extend = {24'd0, sh[7:0]};
      3'b101:  load_extend = {16'd0, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic             w_err_next;
  logic             w_start;
  logic             w_legal;
  logic             w_misal;
  logic             w_fault;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_off;
  logic [2:0]       r_f3;

  assign w_start = load | store;
  assign w_fault = ~w_legal | w_misal;

  // Decode funct3 legality and natural alignment of the requested access.
  always_comb begin
    w_legal = 1'b0;
    w_misal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~store;
      default:                w_legal = 1'b0;
    endcase
    case (funct3[1:0])
      2'b01:   w_misal = addr[0];
      2'b10:   w_misal = addr[1] | addr[0];
      default: w_misal = 1'b0;
    endcase
  end

  // Next-state and error decision.
  always_comb begin
    w_next     = r_state;
    w_err_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next     = w_fault ? S_DONE : S_REQ;
          w_err_next = w_fault;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          w_next = S_DONE;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_next     = S_DONE;
          w_err_next = 1'b1;
        end else begin
          w_next = S_REQ;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Registered status, memory-port and load-result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      rdata     <= 32'd0;
      r_cnt     <= '0;
      r_off     <= 2'd0;
      r_f3      <= 3'd0;
    end else begin
      busy    <= (w_next != S_IDLE);
      done    <= (w_next == S_DONE);
      mem_req <= (w_next == S_REQ);
      err     <= (w_next == S_DONE) & w_err_next;
      if ((r_state == S_IDLE) && w_start && !w_fault) begin
        mem_we    <= store;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= lane_be(funct3, addr[1:0]);
        mem_wdata <= lane_wdata(funct3, wdata);
        r_off     <= addr[1:0];
        r_f3      <= funct3;
        r_cnt     <= '0;
      end else if ((r_state == S_REQ) && !mem_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Only a load completion updates the result; stores and aborts keep it.
      if ((r_state == S_REQ) && mem_ack && !mem_we) begin
        rdata <= load_extend(r_f3, r_off, mem_rdata);
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized operations
// checked against an arithmetic reference model of the access rules.
module tb_load_store_unit;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0, mem_rdata = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        load = 1'b0, store = 1'b0, mem_ack = 1'b0;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] model_rdata = 32'd0;
  logic [31:0] o_be, o_wd, o_ad;

  load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .funct3(funct3),
    .load(load), .store(store), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation end to end; returns the memory-port values seen in the first REQ cycle.
  task automatic run_op(input bit is_st, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3, input int waits, input logic [31:0] word,
                        output logic [31:0] obs_be, output logic [31:0] obs_wd,
                        output logic [31:0] obs_ad);
    bit legal, bad, acked;
    int size;
    logic [31:0] e_be, e_wd, e_ad, v;
    legal = is_st ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                                    f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << f3[1:0];
    bad   = !legal || ((a % size) != 0);
    e_ad  = a - (a % 4);
    e_be  = (((32'd1 << size) - 32'd1) << (a % 4)) & 32'hF;
    if (size == 1)      e_wd = {24'd0, d[7:0]} * 32'h01010101;
    else if (size == 2) e_wd = {16'd0, d[15:0]} * 32'h00010001;
    else                e_wd = d;
    obs_be = 32'd0; obs_wd = 32'd0; obs_ad = 32'd0;
    acked = 1'b0;

    @(negedge clk);
    addr = a; wdata = d; funct3 = f3;
    store = is_st; load = is_st ? 1'($urandom % 2) : 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; store = 1'b0;
    addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);

    if (bad) begin
      check("err_done", 32'(done), 32'd1);
      check("err_err", 32'(err), 32'd1);
      check("err_noreq", 32'(mem_req), 32'd0);
      check("err_busy", 32'(busy), 32'd1);
    end else begin
      obs_be = {28'd0, mem_be}; obs_wd = mem_wdata; obs_ad = mem_addr;
      for (int c = 1; c <= TIMEOUT; c++) begin
        check("req_hi", 32'(mem_req), 32'd1);
        check("req_busy", 32'(busy), 32'd1);
        check("req_nodone", 32'(done), 32'd0);
        check("req_we", 32'(mem_we), 32'(is_st));
        check("req_addr", mem_addr, e_ad);
        check("req_be", {28'd0, mem_be}, e_be);
        if (is_st) check("req_wdata", mem_wdata, e_wd);
        mem_ack = (c - 1 == waits);
        mem_rdata = mem_ack ? word : $urandom;
        @(posedge clk);
        @(negedge clk);
        acked = mem_ack;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (acked) break;
      end
      check("fin_done", 32'(done), 32'd1);
      check("fin_err", 32'(err), acked ? 32'd0 : 32'd1);
      check("fin_noreq", 32'(mem_req), 32'd0);
      if (acked && !is_st) begin
        v = word >> (8 * (a % 4));
        if (size < 4) begin
          v = v & ((32'd1 << (8 * size)) - 32'd1);
          if (!f3[2] && v[8 * size - 1]) v = v - (32'd1 << (8 * size));
        end
        model_rdata = v;
      end
    end
    check("rdata", rdata, model_rdata);
    // A stray ack during DONE must have no effect.
    mem_ack = 1'($urandom % 2);
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_req", 32'(mem_req), 32'd0);
    check("idle_rdata", rdata, model_rdata);
  endtask

  initial begin
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 32'h100, 32'd0, 3'b010, 2, 32'hDEADBEEF, o_be, o_wd, o_ad);
    check("lw_addr", o_ad, 32'h100);
    check("lw_be", o_be, 32'hF);
    check("lw_rdata", rdata, 32'hDEADBEEF);
    run_op(1'b0, 32'h103, 32'd0, 3'b000, 0, 32'h80FF1234, o_be, o_wd, o_ad);
    check("lb_be", o_be, 32'h8);
    check("lb_rdata", rdata, 32'hFFFFFF80);
    run_op(1'b0, 32'h103, 32'd0, 3'b100, 1, 32'h80FF1234, o_be, o_wd, o_ad);
    check("lbu_rdata", rdata, 32'h00000080);
    run_op(1'b0, 32'h102, 32'd0, 3'b101, 0, 32'h80FF1234, o_be, o_wd, o_ad);
    check("lhu_rdata", rdata, 32'h000080FF);
    run_op(1'b1, 32'h206, 32'h1234ABCD, 3'b001, 1, 32'h0, o_be, o_wd, o_ad);
    check("sh_addr", o_ad, 32'h204);
    check("sh_be", o_be, 32'hC);
    check("sh_wdata", o_wd, 32'hABCDABCD);
    check("sh_rdata", rdata, 32'h000080FF);
    run_op(1'b0, 32'h101, 32'd0, 3'b010, 0, 32'h0, o_be, o_wd, o_ad);
    run_op(1'b0, 32'h100, 32'd0, 3'b011, 0, 32'h0, o_be, o_wd, o_ad);
    run_op(1'b1, 32'h300, 32'd0, 3'b100, 0, 32'h0, o_be, o_wd, o_ad);
    run_op(1'b0, 32'h100, 32'd0, 3'b010, 1000, 32'h0, o_be, o_wd, o_ad);

    // Reset asserted in the middle of a request.
    @(negedge clk);
    addr = 32'h100; funct3 = 3'b010; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    check("mid_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    model_rdata = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_done", 32'(done), 32'd0);
    check("late_ack_req", 32'(mem_req), 32'd0);
    run_op(1'b1, 32'h000, 32'h55, 3'b000, 0, 32'h0, o_be, o_wd, o_ad);
    check("sb_be", o_be, 32'h1);
    check("sb_wdata", o_wd, 32'h55555555);

    for (int i = 0; i < 60; i++) begin
      bit st;
      logic [2:0] f3;
      int w;
      st = 1'($urandom % 2);
      if ($urandom % 4 == 0) f3 = 3'($urandom);
      else if (st) f3 = 3'($urandom % 3);
      else begin
        case ($urandom % 5)
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      w = ($urandom % 10 == 0) ? 30 : int'($urandom % 4);
      run_op(st, $urandom, $urandom, f3, w, $urandom, o_be, o_wd, o_ad);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the rv32i data path.
- Takes the ALU result as the effective address plus the store operand, and runs one load or store on a word-wide data-memory port with a req/ack handshake.
- Produces byte/halfword-aligned, sign- or zero-extended load data for writeback, plus done and error status.
- Multi-cycle: holds the core busy while memory responds, and aborts on timeout.

Parameters:
TIMEOUT, 16, max cycles to wait for mem_ack in REQ before aborting; 0 disables the timeout
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
addr  in  32  effective address (ALU res)
wdata  in  32  store data (rs2)
funct3  in  3  RV32I load/store width code
load  in  1  start a load (sampled in IDLE only)
store  in  1  start a store (sampled in IDLE only)
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
err  out  1  valid with done: misaligned, illegal funct3 or timeout
rdata  out  32  extended load result, valid from done until the next load completes
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word, valid when mem_ack=1
mem_ack  in  1  memory completion

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, err, mem_req and mem_we go to 0 at once.
  - mem_addr, mem_be, mem_wdata and rdata = 0. Wait counter = 0.
- States: IDLE, REQ, DONE.
- IDLE:
  - On an edge with load|store=1, latch addr, wdata, funct3 and op. store has priority if both are high.
  - Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal for stores: 000, 001, 010.
  - Illegal funct3, halfword with addr[0]=1, or word with addr[1:0]!=0 -> go to DONE with err=1 and no memory access.
  - Otherwise -> REQ with busy=1, mem_req=1, mem_we=store, mem_addr and mem_be driven, counter cleared.
- mem_be:
  - Byte: 4'b0001<<addr[1:0].
  - Halfword: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
  - Loads drive the same enables.
- mem_wdata:
  - Byte: {4{wdata[7:0]}}.
  - Halfword: {2{wdata[15:0]}}.
  - Word: wdata.
- REQ:
  - mem_req and all mem_* outputs stay stable until mem_ack is sampled high.
  - On ack: go to DONE, mem_req=0 on the following cycle, err=0.
  - On a load ack, also register rdata = lane select of mem_rdata by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
  - Store ack leaves rdata unchanged.
  - Counter increments each REQ cycle without ack. If TIMEOUT!=0 and counter reaches TIMEOUT-1 with no ack, go to DONE with err=1, mem_req=0, rdata unchanged.
- DONE (exactly one cycle): done=1, busy=1, then go to IDLE with busy=0 and done=0.
  - Start is not accepted in DONE, so back-to-back operations are spaced by one IDLE cycle.
- Latency: start edge -> mem_req high the next cycle. Ack with zero wait gives done 2 cycles after start. Error paths give done 1 cycle after start.
- Ignored inputs:
  - mem_ack in IDLE or DONE.
  - load/store while busy.
- Reset mid-REQ: mem_req drops asynchronously, no done pulse, and a late ack after reset is ignored.

Test Plan:
- LW at addr 0x100 with mem_rdata=0xDEADBEEF, ack after 2 wait cycles -> mem_addr=0x100, mem_be=1111, done 4 cycles after start, rdata=0xDEADBEEF, err=0.
- LB at addr 0x103, mem_rdata=0x80FF1234 -> mem_be=1000, rdata=0xFFFFFF80. LBU at the same address -> rdata=0x00000080. LHU at 0x102 -> rdata=0x000080FF.
- SH at addr 0x206, wdata=0x1234ABCD -> mem_we=1, mem_addr=0x204, mem_be=1100, mem_wdata=0xABCDABCD, rdata unchanged after done.
- Misaligned LW at 0x101 and illegal funct3=011 -> mem_req never rises, done with err=1 one cycle after start.
- TIMEOUT=16 with mem_ack held low -> mem_req high 16 cycles, then done with err=1, mem_req=0. A later ack is ignored.
- rst_n pulsed low while in REQ -> mem_req, busy and done drop immediately. After release, a new SB at 0x000 with wdata=0x55 gives mem_be=0001 and mem_wdata=0x55555555.
